// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit: TinyRV1 F stage. Owns the PC, issues imem requests over
// val/rdy, buffers in-order responses and presents one instruction per cycle
// to D. Redirects flush buffered instructions and retire stale in-flight
// responses through a drop counter.
// Optional feature: define PROC_FETCH_DROP_CNT_EN to add f2d_drop_cnt, a
// saturating count of discarded responses.
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0200,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c2f_reg_en_F,
  input  logic [1:0]  c2f_pc_sel_F,
  input  logic [31:0] d2f_jal_targ,
  input  logic [31:0] d2f_jr_targ,
  input  logic [31:0] d2f_br_targ,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  output logic        f2d_val,
  output logic [31:0] f2d_inst,
`ifdef PROC_FETCH_DROP_CNT_EN
  output logic [15:0] f2d_drop_cnt,
`endif
  output logic [31:0] f2d_pc
);

  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] MAX_OCC = OW'(MAX_INFLIGHT);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_ent_t;

  logic [31:0]                   pc;
  logic [MAX_INFLIGHT-1:0][31:0] pend_pc;
  logic [PW-1:0]                 pend_rd, pend_wr;
  logic [CW-1:0]                 pend_cnt;
  iq_ent_t [MAX_INFLIGHT-1:0]    iq;
  logic [PW-1:0]                 iq_rd, iq_wr;
  logic [CW-1:0]                 iq_cnt;
  logic [CW-1:0]                 drop_cnt;

  logic [OW-1:0] occ;
  logic          redirect, req_fire, resp_fire, drop_hit, enq, deq;
  logic [31:0]   targ;

  // Space is reserved at issue, so the response side never backpressures.
  assign occ          = OW'(pend_cnt) + OW'(iq_cnt);
  assign redirect     = (c2f_pc_sel_F != 2'd0);
  assign imemreq_val  = ~rst & (occ < MAX_OCC) & ~redirect;
  assign imemreq_addr = pc;
  assign imemresp_rdy = 1'b1;
  assign req_fire     = imemreq_val & imemreq_rdy;
  assign resp_fire    = imemresp_val;
  assign drop_hit     = resp_fire & (drop_cnt != '0);
  // A response landing in a redirect cycle is stale as well, so never enqueue it.
  assign enq          = resp_fire & ~drop_hit & ~redirect;
  assign deq          = c2f_reg_en_F & (iq_cnt != '0) & ~redirect;

  assign f2d_val  = (iq_cnt != '0);
  assign f2d_inst = f2d_val ? iq[iq_rd].inst : 32'h0;
  assign f2d_pc   = f2d_val ? iq[iq_rd].pc   : 32'h0;

  // Redirect target select.
  always_comb begin
    targ = pc;
    case (c2f_pc_sel_F)
      2'd1:    targ = d2f_jal_targ;
      2'd2:    targ = d2f_jr_targ;
      2'd3:    targ = d2f_br_targ;
      default: targ = pc;
    endcase
  end

  // PC: redirect wins; otherwise advance on each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= targ;
    else if (req_fire) pc <= pc + 32'd4;
  end

  // Pending-PC FIFO control; entries survive redirects and drain as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rd  <= '0;
      pend_wr  <= '0;
      pend_cnt <= '0;
    end else begin
      if (req_fire)  pend_wr <= pend_wr + 1'b1;
      if (resp_fire) pend_rd <= pend_rd + 1'b1;
      pend_cnt <= pend_cnt + CW'(req_fire) - CW'(resp_fire);
    end
  end

  // Instruction FIFO control; a redirect empties it in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iq_rd  <= '0;
      iq_wr  <= '0;
      iq_cnt <= '0;
    end else if (redirect) begin
      iq_rd  <= iq_wr;
      iq_cnt <= '0;
    end else begin
      if (enq) iq_wr <= iq_wr + 1'b1;
      if (deq) iq_rd <= iq_rd + 1'b1;
      iq_cnt <= iq_cnt + CW'(enq) - CW'(deq);
    end
  end

  // FIFO storage needs no reset; occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (req_fire) pend_pc[pend_wr] <= pc;
    if (enq)      iq[iq_wr] <= '{inst: imemresp_data, pc: pend_pc[pend_rd]};
  end

  // Drop counter: on redirect every still-pending response becomes stale,
  // minus the one being discarded right now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           drop_cnt <= '0;
    else if (redirect) drop_cnt <= pend_cnt - CW'(resp_fire);
    else if (drop_hit) drop_cnt <= drop_cnt - 1'b1;
  end

`ifdef PROC_FETCH_DROP_CNT_EN
  logic [15:0] drop_tot;
  logic        discard;

  assign discard      = resp_fire & (drop_hit | redirect);
  assign f2d_drop_cnt = drop_tot;

  // Saturating count of every discarded response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  drop_tot <= '0;
    else if (discard && drop_tot != 16'hFFFF) drop_tot <= drop_tot + 16'd1;
  end
`endif

endmodule
